// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive frame controller
package uart_rx_pkg;

    localparam int UART_RX_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - serial line, counter-stage and register-side signals of the Rx controller
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = uart_rx_pkg::UART_RX_DATA_WIDTH
);
    logic                  RX_IN;
    logic [7:0]            Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [7:0]            Edge_Cnt;
    logic [3:0]            Bit_Cnt;
    logic                  Count_En;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Par_Err;
    logic                  Stp_Err;

    modport master (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP, Edge_Cnt, Bit_Cnt,
        output Count_En, P_DATA, Data_Valid, Par_Err, Stp_Err
    );

    modport slave (
        output RX_IN, Prescale, PAR_EN, PAR_TYP, Edge_Cnt, Bit_Cnt,
        input  Count_En, P_DATA, Data_Valid, Par_Err, Stp_Err
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - three-point mid-bit capture of RX_IN with registered 2-of-3 majority
module uart_rx_sampler
    import uart_rx_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic [7:0] Prescale,
    input  logic [7:0] Edge_Cnt,
    output logic       o_sampled_bit
);

    logic [7:0] w_mid;
    logic       r_s0;
    logic       r_s1;
    logic       r_bit;

    assign w_mid = {1'b0, Prescale[7:1]};

    // The third sample is voted directly so the bit is ready the cycle after mid+1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0  <= 1'b0;
            r_s1  <= 1'b0;
            r_bit <= 1'b0;
        end else begin
            if (Edge_Cnt == w_mid - 8'd1) r_s0 <= RX_IN;
            if (Edge_Cnt == w_mid)        r_s1 <= RX_IN;
            if (Edge_Cnt == w_mid + 8'd1) r_bit <= maj3(r_s0, r_s1, RX_IN);
        end
    end

    assign o_sampled_bit = r_bit;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART Rx frame FSM; parity support built only with UART_RX_PARITY_EN defined
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_RX_DATA_WIDTH
) (
    input  logic          CLK,
    input  logic          RST,
    uart_rx_ctrl_if.master bus
);

    uart_rx_state_t        r_state;
    uart_rx_state_t        w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_pdata;
    logic                  r_dv;
    logic                  r_pe;
    logic                  r_se;
    logic                  w_dv_nxt;
    logic                  w_pe_nxt;
    logic                  w_se_nxt;
    logic                  w_bit;
    logic                  w_eob;
    logic                  r_par_flag;

    uart_rx_sampler u_sampler (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (bus.RX_IN),
        .Prescale      (bus.Prescale),
        .Edge_Cnt      (bus.Edge_Cnt),
        .o_sampled_bit (w_bit)
    );

    assign w_eob = (r_state != IDLE) && (bus.Edge_Cnt == bus.Prescale);

`ifdef UART_RX_PARITY_EN
    logic r_par_en;
    logic r_par_typ;

    // Parity options are frozen for the whole frame; the flag is cleared each time we idle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_par_en   <= 1'b0;
            r_par_typ  <= PAR_EVEN;
            r_par_flag <= 1'b0;
        end else if (r_state == IDLE) begin
            r_par_en   <= bus.PAR_EN;
            r_par_typ  <= bus.PAR_TYP;
            r_par_flag <= 1'b0;
        end else if ((r_state == PARITY) && w_eob) begin
            r_par_flag <= w_bit ^ (^r_shift) ^ (r_par_typ == PAR_ODD);
        end
    end
`else
    logic w_unused_par;
    assign w_unused_par = ^{bus.PAR_EN, bus.PAR_TYP};
    assign r_par_flag   = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dv_nxt    = 1'b0;
        w_pe_nxt    = 1'b0;
        w_se_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!bus.RX_IN) w_state_nxt = START;
            end
            START: begin
                if (w_eob && (bus.Bit_Cnt == 4'd0)) w_state_nxt = w_bit ? IDLE : DATA;
            end
            DATA: begin
                if (w_eob && (bus.Bit_Cnt == 4'(DATA_WIDTH))) begin
`ifdef UART_RX_PARITY_EN
                    w_state_nxt = r_par_en ? PARITY : STOP;
`else
                    w_state_nxt = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (w_eob) w_state_nxt = STOP;
            end
`endif
            STOP: begin
                if (w_eob) begin
                    w_state_nxt = IDLE;
                    if (!w_bit)          w_se_nxt = 1'b1;
                    else if (r_par_flag) w_pe_nxt = 1'b1;
                    else                 w_dv_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_shift <= '0;
            r_pdata <= '0;
            r_dv    <= 1'b0;
            r_pe    <= 1'b0;
            r_se    <= 1'b0;
        end else begin
            r_dv <= w_dv_nxt;
            r_pe <= w_pe_nxt;
            r_se <= w_se_nxt;
            if ((r_state == DATA) && w_eob) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (bus.Bit_Cnt == 4'(i + 1)) r_shift[i] <= w_bit;
                end
            end
            if (w_dv_nxt) r_pdata <= r_shift;
        end
    end

    assign bus.Count_En   = (r_state != IDLE);
    assign bus.P_DATA     = r_pdata;
    assign bus.Data_Valid = r_dv;
    assign bus.Par_Err    = r_pe;
    assign bus.Stp_Err    = r_se;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - scoreboard bench for uart_rx_ctrl with a behavioural counter stage
module tb_uart_rx_ctrl;

    localparam logic [2:0] K_VALID = 3'b001;
    localparam logic [2:0] K_PAR   = 3'b010;
    localparam logic [2:0] K_STP   = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic r_line = 1'b1;
    logic noise_en = 1'b0;
    logic w_noise;
    logic prev_eob = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    exp_t e;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.Edge_Cnt = 8'd0;
        bus.Bit_Cnt  = 4'd0;
    end

    always @(posedge clk or negedge bus.Count_En) begin
        if (!bus.Count_En) begin
            bus.Edge_Cnt <= 8'd0;
            bus.Bit_Cnt  <= 4'd0;
        end else if (bus.Edge_Cnt == bus.Prescale) begin
            bus.Edge_Cnt <= 8'd1;
            bus.Bit_Cnt  <= bus.Bit_Cnt + 4'd1;
        end else begin
            bus.Edge_Cnt <= bus.Edge_Cnt + 8'd1;
        end
    end

    assign w_noise = noise_en && bus.Count_En && (bus.Bit_Cnt >= 4'd1) && (bus.Bit_Cnt <= 4'd8)
                     && (bus.Edge_Cnt == {1'b0, bus.Prescale[7:1]});
    assign bus.RX_IN = r_line ^ w_noise;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (bus.Data_Valid || bus.Par_Err || bus.Stp_Err)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, bus.Stp_Err, bus.Par_Err, bus.Data_Valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("outcome_kind", {29'd0, bus.Stp_Err, bus.Par_Err, bus.Data_Valid}, {29'd0, e.kind});
                check("P_DATA", {24'd0, bus.P_DATA}, {24'd0, e.data});
                check("latency_after_stop_eob", {31'd0, prev_eob}, 32'd1);
                check("count_en_low_at_pulse", {31'd0, bus.Count_En}, 32'd0);
            end
        end
        prev_eob <= bus.Count_En && (bus.Edge_Cnt == bus.Prescale);
    end

    task automatic push(input logic [2:0] kind, input logic [7:0] data);
        exp_t x;
        x.kind = kind;
        x.data = data;
        exp_q.push_back(x);
    endtask

    task automatic send_bit(input logic b);
        r_line = b;
        repeat (int'(bus.Prescale)) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic has_par, input logic par_bit,
                              input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (has_par) send_bit(par_bit);
        send_bit(stop_bit);
        r_line = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Prescale = 8'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        gap(3);
        check("reset_count_en", {31'd0, bus.Count_En}, 32'd0);
        check("reset_p_data", {24'd0, bus.P_DATA}, 32'd0);
        check("reset_data_valid", {31'd0, bus.Data_Valid}, 32'd0);
        check("reset_par_err", {31'd0, bus.Par_Err}, 32'd0);
        check("reset_stp_err", {31'd0, bus.Stp_Err}, 32'd0);
        rst_n = 1'b1;
        gap(2);

        push(K_VALID, 8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        gap(4);
        check("basic_count_en_after", {31'd0, bus.Count_En}, 32'd0);

        bus.Prescale = 8'd16;
        bus.PAR_EN   = 1'b1;
        bus.PAR_TYP  = 1'b0;
        gap(2);
`ifdef UART_RX_PARITY_EN
        push(K_VALID, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        gap(6);
        push(K_PAR, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        gap(6);
        bus.PAR_TYP = 1'b1;
        gap(2);
        push(K_VALID, 8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
        gap(6);
`else
        push(K_VALID, 8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        gap(6);
`endif

        bus.Prescale = 8'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        gap(2);
        push(K_STP, 8'h3C);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        gap(6);
        check("stop_err_back_to_idle", {31'd0, bus.Count_En}, 32'd0);

        bus.Prescale = 8'd16;
        gap(2);
        r_line = 1'b0;
        gap(3);
        r_line = 1'b1;
        check("glitch_count_en_high", {31'd0, bus.Count_En}, 32'd1);
        gap(20);
        check("glitch_count_en_low", {31'd0, bus.Count_En}, 32'd0);

        bus.Prescale = 8'd8;
        gap(4);
        push(K_VALID, 8'h5A);
        push(K_VALID, 8'hC3);
        noise_en = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        noise_en = 1'b0;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        gap(8);

        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        r_line = 1'b1;
        gap(4);
        rst_n = 1'b0;
        #1;
        check("rst_mid_count_en", {31'd0, bus.Count_En}, 32'd0);
        check("rst_mid_p_data", {24'd0, bus.P_DATA}, 32'd0);
        check("rst_mid_pulses", {29'd0, bus.Stp_Err, bus.Par_Err, bus.Data_Valid}, 32'd0);
        gap(3);
        rst_n = 1'b1;
        gap(4);
        push(K_VALID, 8'h66);
        send_frame(8'h66, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        gap(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
